fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO, next generation of the team's fixed 8-bit buffer. Width, depth and programmable almost-full/almost-empty thresholds are parameters. Adds an occupancy count, sticky overflow/underflow error flags, and a selectable read mode: standard registered read or first-word-fall-through. It sits between producer and consumer blocks in a single clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
ADDR_W, $clog2(DEPTH), pointer width; derived, never overridden
AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  synchronous, active-high reset
EN  in  1  global enable; when 0 no read, write or error update occurs
WR  in  1  write request
RD  in  1  read request (pop)
dataIn  in  DATA_W  write data
CLR_ERR  in  1  clears OVERFLOW/UNDERFLOW (works regardless of EN)
dataOut  out  DATA_W  read data
EMPTY  out  1  COUNT == 0
FULL  out  1  COUNT == DEPTH
ALMOST_FULL  out  1  COUNT >= AF_LEVEL
ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL
COUNT  out  ADDR_W+1  current occupancy, 0..DEPTH
OVERFLOW  out  1  sticky: write attempted while full and not accepted
UNDERFLOW  out  1  sticky: read attempted while empty

Behaviour:
- Reset (Rst=1 at a Clk edge, overrides everything): rd/wr pointers=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=(AF_LEVEL==0 ? 1 : 0) (AF_LEVEL>=1, so 0), OVERFLOW=0, UNDERFLOW=0, dataOut=0. Memory contents are not cleared. Reset mid-operation discards all stored data.
- All outputs are registered or decoded from registered COUNT; no combinational path from RD/WR to flags.
- Accepted write: EN & WR & (!FULL | accepted read same cycle). Stores dataIn at wr_ptr; wr_ptr increments modulo DEPTH.
- Accepted read: EN & RD & !EMPTY. rd_ptr increments modulo DEPTH.
- FULL with RD&WR both high: both accepted, COUNT unchanged, no OVERFLOW.
- EMPTY with RD&WR both high: write accepted, read rejected, UNDERFLOW set, COUNT becomes 1.
- COUNT next = COUNT + accepted_write - accepted_read; all flags update in the same cycle as COUNT.
- OVERFLOW set on EN & WR & FULL & !RD. UNDERFLOW set on EN & RD & EMPTY. Both stay set until CLR_ERR or Rst; if set and CLR_ERR occur together, set wins.
- Rejected operations leave pointers, COUNT and memory untouched.
- FWFT=0: on an accepted read, dataOut loads the head word at the next edge (1-cycle latency). Otherwise dataOut holds its value.
- FWFT=1: dataOut always presents the head word while !EMPTY, valid the cycle after the write that makes the FIFO non-empty. RD pops it and the next word appears the following cycle. dataOut is don't-care (hold last) while EMPTY.
- EN=0: pointers, COUNT, flags and dataOut hold. CLR_ERR is still honoured.
- Pointer wrap: pointers are ADDR_W bits and wrap naturally. Full/empty are distinguished by COUNT, not by pointer comparison.

Decomposition:
- Package fifo_pkg: read-mode constants (FIFO_STD=0, FIFO_FWFT=1) and a threshold-check helper function. No types depend on DATA_W.
- One sub-module: fifo_mem_dp, a simple dual-port array (DEPTH x DATA_W, one write port, one synchronous read port) so technology memory can be swapped in. Pointer, count, flag and error logic stays in the top level.

Test Plan:
(All scenarios: DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2, FWFT=0.)
- Reset then 4 writes 01..04 -> COUNT=4, EMPTY=0, ALMOST_EMPTY=0; 4 reads -> dataOut 01,02,03,04 each one cycle after RD; EMPTY=1, COUNT=0.
- Write 8 words AA..B1 -> ALMOST_FULL at COUNT=6, FULL at 8. A 9th write with RD=0 -> OVERFLOW=1, COUNT=8, data unchanged. CLR_ERR -> OVERFLOW=0.
- While FULL, RD=WR=1 with dataIn=C0 -> COUNT stays 8, dataOut=AA, and C0 is read out last after a full drain.
- While EMPTY, RD=1 -> UNDERFLOW=1, dataOut holds. RD=WR=1 with dataIn=55 -> COUNT=1, UNDERFLOW stays 1.
- Wrap-around: 20 interleaved write/read pairs (values 00..13) -> output order matches input exactly, and COUNT never exceeds 1.
- Rst asserted with COUNT=5 -> next cycle COUNT=0, EMPTY=1, all flags at reset values. Rerun the first scenario with FWFT=1 -> dataOut=01 visible before the first RD.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared read-mode constants and threshold helper for the parametrised FIFO.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic logic level_ge(input int unsigned value, input int unsigned level);
        return value >= level;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one write port and one registered read port.
// Only the read register is reset; the array keeps its contents.
module fifo_mem_dp #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-before-write: a same-address write in the same cycle returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, thresholds, sticky
// error flags and selectable registered / first-word-fall-through read.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int DEPTH    = 16,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
    parameter  int FWFT     = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              EN,
    input  logic              WR,
    input  logic              RD,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              CLR_ERR,
    output logic [DATA_W-1:0] dataOut,
    output logic              EMPTY,
    output logic              FULL,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int CNT_W   = ADDR_W + 1;
    localparam bit IS_FWFT = (FWFT == FIFO_FWFT);

    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf, r_unf;
    logic              r_byp;
    logic [DATA_W-1:0] r_byp_data;

    logic              w_empty, w_full;
    logic              w_rd_acc, w_wr_acc;
    logic              w_ovf_set, w_unf_set;
    logic [ADDR_W-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_mem_re, w_byp;
    logic [ADDR_W-1:0] w_mem_raddr;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_rd_acc     = EN & RD & ~w_empty;
    assign w_wr_acc     = EN & WR & (~w_full | w_rd_acc);
    assign w_ovf_set    = EN & WR & w_full & ~RD;
    assign w_unf_set    = EN & RD & w_empty;
    assign w_wr_ptr_nxt = w_wr_acc ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd_acc ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;
    assign w_count_nxt  = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);

    // FWFT keeps the read register tracking the next head; a write landing on
    // that head slot is forwarded because the array returns the old word.
    assign w_mem_re    = IS_FWFT ? (EN & (w_count_nxt != '0)) : w_rd_acc;
    assign w_mem_raddr = IS_FWFT ? w_rd_ptr_nxt : r_rd_ptr;
    assign w_byp       = IS_FWFT & w_wr_acc & (r_wr_ptr == w_rd_ptr_nxt);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_ovf    <= w_ovf_set | (r_ovf & ~CLR_ERR);
            r_unf    <= w_unf_set | (r_unf & ~CLR_ERR);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_byp      <= 1'b0;
            r_byp_data <= '0;
        end else if (w_mem_re) begin
            r_byp <= w_byp;
            if (w_byp) begin
                r_byp_data <= dataIn;
            end
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (Clk),
        .i_rst   (Rst),
        .i_we    (w_wr_acc & ~Rst),
        .i_waddr (r_wr_ptr),
        .i_wdata (dataIn),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_raddr),
        .o_rdata (w_mem_rdata)
    );

    assign dataOut      = r_byp ? r_byp_data : w_mem_rdata;
    assign COUNT        = r_count;
    assign EMPTY        = w_empty;
    assign FULL         = w_full;
    assign ALMOST_FULL  = level_ge(32'(r_count), AF_LEVEL);
    assign ALMOST_EMPTY = ~level_ge(32'(r_count), AE_LEVEL + 1);
    assign OVERFLOW     = r_ovf;
    assign UNDERFLOW    = r_unf;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: read data is scoreboarded through an
// expected queue, flags and counts are checked inline after each cycle.
module tb_fifo_sync_param;

    logic       Clk = 1'b0;
    logic       Rst, EN, WR, RD, CLR_ERR;
    logic [7:0] dataIn;

    logic [7:0] dataOut;
    logic       EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
    logic [3:0] COUNT;

    logic [7:0] f_dataOut;
    logic       f_EMPTY, f_FULL, f_ALMOST_FULL, f_ALMOST_EMPTY, f_OVERFLOW, f_UNDERFLOW;
    logic [3:0] f_COUNT;

    logic       rd_strobe = 1'b0;
    logic       mon_due   = 1'b0;
    int         n_cmp     = 0;
    int         n_err     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] drain_exp [8];

    fifo_sync_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut (
        .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .RD(RD), .dataIn(dataIn), .CLR_ERR(CLR_ERR),
        .dataOut(dataOut), .EMPTY(EMPTY), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    fifo_sync_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_f (
        .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .RD(RD), .dataIn(dataIn), .CLR_ERR(CLR_ERR),
        .dataOut(f_dataOut), .EMPTY(f_EMPTY), .FULL(f_FULL), .ALMOST_FULL(f_ALMOST_FULL),
        .ALMOST_EMPTY(f_ALMOST_EMPTY), .COUNT(f_COUNT), .OVERFLOW(f_OVERFLOW),
        .UNDERFLOW(f_UNDERFLOW)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic wr, input logic rd, input logic [7:0] din,
                        input logic clr, input logic strobe, input logic [7:0] exp_d);
        WR = wr; RD = rd; dataIn = din; CLR_ERR = clr; rd_strobe = strobe;
        if (strobe) exp_q.push_back(exp_d);
        @(posedge Clk);
        #1;
        WR = 1'b0; RD = 1'b0; CLR_ERR = 1'b0; rd_strobe = 1'b0;
    endtask

    task automatic do_wr(input logic [7:0] din);
        tick(1'b1, 1'b0, din, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_rd(input logic [7:0] exp_d);
        tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, exp_d);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    // Registered-read monitor: data is due one edge after a strobed read.
    initial begin
        forever begin
            @(posedge Clk);
            mon_due = rd_strobe;
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge Clk);
            if (mon_due) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_data: got %0h, expected queue empty (t=%0t)", dataOut, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (dataOut !== e) begin
                        n_err++;
                        $display("FAIL rd_data: got %0h, expected %0h (t=%0t)", dataOut, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        drain_exp = '{8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB0, 8'hB1, 8'hC0};
        Rst = 1'b1; EN = 1'b1; WR = 1'b0; RD = 1'b0; CLR_ERR = 1'b0; dataIn = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;

        chk("rst_count", COUNT, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_ae", ALMOST_EMPTY, 1);
        chk("rst_af", ALMOST_FULL, 0);
        chk("rst_ovf", OVERFLOW, 0);
        chk("rst_unf", UNDERFLOW, 0);
        chk("rst_dout", dataOut, 8'h00);

        // Basic write/read order
        do_wr(8'h01); do_wr(8'h02); do_wr(8'h03); do_wr(8'h04);
        chk("s1_count4", COUNT, 4);
        chk("s1_empty0", EMPTY, 0);
        chk("s1_ae0", ALMOST_EMPTY, 0);
        do_rd(8'h01); do_rd(8'h02);
        chk("s1_ae_at2", ALMOST_EMPTY, 1);
        do_rd(8'h03); do_rd(8'h04);
        chk("s1_empty1", EMPTY, 1);
        chk("s1_count0", COUNT, 0);

        // Fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            do_wr(8'hAA + 8'(i));
            if (i == 4) chk("s2_af_at5", ALMOST_FULL, 0);
            if (i == 5) chk("s2_af_at6", ALMOST_FULL, 1);
            if (i == 6) chk("s2_full_at7", FULL, 0);
        end
        chk("s2_full", FULL, 1);
        chk("s2_count8", COUNT, 8);
        do_wr(8'hFF);
        chk("s2_ovf", OVERFLOW, 1);
        chk("s2_ovf_count", COUNT, 8);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("s2_ovf_clr", OVERFLOW, 0);

        // Simultaneous read/write while full, then drain
        tick(1'b1, 1'b1, 8'hC0, 1'b0, 1'b1, 8'hAA);
        chk("s3_count", COUNT, 8);
        chk("s3_no_ovf", OVERFLOW, 0);
        for (int i = 0; i < 8; i++) do_rd(drain_exp[i]);
        chk("s3_empty", EMPTY, 1);

        // Underflow behaviour and error clearing
        tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("s4_unf", UNDERFLOW, 1);
        chk("s4_dout_hold", dataOut, 8'hC0);
        tick(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
        chk("s4_count1", COUNT, 1);
        chk("s4_unf_stays", UNDERFLOW, 1);
        chk("s4_dout_hold2", dataOut, 8'hC0);
        do_rd(8'h55);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("s4_unf_clr", UNDERFLOW, 0);
        tick(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("s4_set_wins", UNDERFLOW, 1);
        EN = 1'b0;
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("s4_clr_no_en", UNDERFLOW, 0);
        tick(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
        chk("s4_en0_count", COUNT, 0);
        chk("s4_en0_unf", UNDERFLOW, 0);
        EN = 1'b1;

        // Pointer wrap-around
        for (int i = 0; i < 20; i++) begin
            do_wr(8'(i));
            chk("s5_count_le1", 32'(COUNT <= 4'd1), 1);
            do_rd(8'(i));
        end
        chk("s5_empty", EMPTY, 1);

        // Reset mid-operation
        tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) do_wr(8'h60 + 8'(i));
        chk("s6_count5", COUNT, 5);
        chk("s6_unf_pre", UNDERFLOW, 1);
        Rst = 1'b1;
        idle();
        Rst = 1'b0;
        chk("s6_count0", COUNT, 0);
        chk("s6_empty", EMPTY, 1);
        chk("s6_ae", ALMOST_EMPTY, 1);
        chk("s6_af", ALMOST_FULL, 0);
        chk("s6_ovf", OVERFLOW, 0);
        chk("s6_unf", UNDERFLOW, 0);
        chk("s6_dout", dataOut, 8'h00);

        // First-word-fall-through instance
        chk("s7_f_rst_dout", f_dataOut, 8'h00);
        do_wr(8'h01);
        chk("s7_f_first", f_dataOut, 8'h01);
        do_wr(8'h02); do_wr(8'h03); do_wr(8'h04);
        chk("s7_f_head", f_dataOut, 8'h01);
        chk("s7_f_count", f_COUNT, 4);
        do_rd(8'h01);
        chk("s7_f_pop1", f_dataOut, 8'h02);
        do_rd(8'h02);
        chk("s7_f_pop2", f_dataOut, 8'h03);
        do_rd(8'h03);
        chk("s7_f_pop3", f_dataOut, 8'h04);
        do_rd(8'h04);
        chk("s7_f_hold", f_dataOut, 8'h04);
        chk("s7_f_empty", f_EMPTY, 1);

        repeat (2) idle();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
